// File: rtl/wallace_mul_share_ctrl.sv
// Time-shares one combinational 8x8 Wallace-tree multiplier among NREQ requesters.
// Arbitration is round-robin, and each product is returned tagged with the owning requester's index.

module WallaceMul8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [15:0] csa_sum(input logic [15:0] u, input logic [15:0] v,
                                          input logic [15:0] w);
    return u ^ v ^ w;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] u, input logic [15:0] v,
                                            input logic [15:0] w);
    return ((u & v) | (u & w) | (v & w)) << 1;
  endfunction

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // Reduce 8 partial-product rows through 3:2 compressor layers (8 -> 6 -> 4 -> 3 -> 2),
  // then resolve the last two rows with one carry-propagate adder.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'b0, a & {8{b[i]}}} << i;
    end
    s0 = csa_sum(pp[0], pp[1], pp[2]);
    c0 = csa_carry(pp[0], pp[1], pp[2]);
    s1 = csa_sum(pp[3], pp[4], pp[5]);
    c1 = csa_carry(pp[3], pp[4], pp[5]);
    s2 = csa_sum(s0, c0, s1);
    c2 = csa_carry(s0, c0, s1);
    s3 = csa_sum(c1, pp[6], pp[7]);
    c3 = csa_carry(c1, pp[6], pp[7]);
    s4 = csa_sum(s2, c2, s3);
    c4 = csa_carry(s2, c2, s3);
    s5 = csa_sum(s4, c4, c3);
    c5 = csa_carry(s4, c4, c3);
    p  = s5 + c5;
  end

endmodule

module wallace_mul_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_x,
  input  logic [8*NREQ-1:0]   req_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [15:0]         rsp_p,
  output logic                busy
);

  localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_p_q, rsp_p_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic [7:0]        sel_x, sel_y;
  logic [15:0]       mul_p;
  int                idx;

  WallaceMul8x8 u_mul (
    .a (x_q),
    .b (y_q),
    .p (mul_p)
  );

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_x = req_x[8*i +: 8];
        sel_y = req_y[8*i +: 8];
        req_ready[i] = (state_q == IDLE) && grant_found;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          x_d      = sel_x;
          y_d      = sel_y;
          id_d     = grant_idx;
          cnt_d    = CNTW'(MUL_LAT - 1);
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          rsp_p_d     = mul_p;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wallace_mul_share_ctrl.sv
// Randomised bench for wallace_mul_share_ctrl against a round-robin, plain-multiply model.

module tb_wallace_mul_share_ctrl;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_x;
  logic [8*NREQ-1:0]   req_y;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_p;
  logic                busy;

  int checks_total  = 0;
  int checks_passed = 0;
  int model_ptr     = 0;
  logic [7:0] op_x [NREQ];
  logic [7:0] op_y [NREQ];

  always #5 clk = ~clk;

  wallace_mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic int model_grant(input int ptr, input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic load_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_x[8*i +: 8] = op_x[i];
      req_y[8*i +: 8] = op_y[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
  endtask

  // One full transaction: grant, latency, response, optional backpressure, handshake.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int hold, input bit early_ready);
    int g;
    int n;
    logic [15:0] exp_p;
    g = model_grant(model_ptr, mask);
    load_operands();
    req_valid = mask;
    rsp_ready = early_ready;
    @(negedge clk);
    checkOutput("req_ready", 32'(req_ready), 32'(1) << g);
    exp_p = 16'(op_x[g]) * 16'(op_y[g]);
    @(posedge clk);
    #1;
    checkOutput("busy_calc", 32'(busy), 1);
    n = 0;
    while (!rsp_valid && n < 4 * MUL_LAT + 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 1);
    checkOutput("latency", n, MUL_LAT);
    checkOutput("rsp_p", 32'(rsp_p), 32'(exp_p));
    checkOutput("rsp_id", 32'(rsp_id), g);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(rsp_valid), 1);
      checkOutput("hold_p", 32'(rsp_p), 32'(exp_p));
      checkOutput("hold_id", 32'(rsp_id), g);
      checkOutput("hold_ready", 32'(req_ready), 0);
      checkOutput("hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    checkOutput("rsp_done", 32'(rsp_valid), 0);
    checkOutput("idle", 32'(busy), 0);
    checkOutput("p_kept", 32'(rsp_p), 32'(exp_p));
    model_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ext_x [4];
    logic [7:0] ext_y [4];
    logic [NREQ-1:0] m;
    int hold;

    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_x[i] = '0;
      op_y[i] = '0;
    end
    do_reset();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(rsp_valid), 0);
    checkOutput("rst_p", 32'(rsp_p), 0);
    checkOutput("rst_id", 32'(rsp_id), 0);
    checkOutput("rst_ready", 32'(req_ready), 0);

    $display("[TB] single op");
    op_x[0] = 8'd13;
    op_y[0] = 8'd11;
    applyStimulus(4'b0001, 0, 1'b0);

    $display("[TB] extremes on requester 1");
    ext_x = '{8'd255, 8'd0, 8'd128, 8'd1};
    ext_y = '{8'd255, 8'd200, 8'd2, 8'd255};
    for (int i = 0; i < 4; i++) begin
      op_x[1] = ext_x[i];
      op_y[1] = ext_y[i];
      applyStimulus(4'b0010, 0, 1'b0);
    end

    $display("[TB] round robin from reset");
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        op_x[r] = 8'($urandom);
        op_y[r] = 8'($urandom);
      end
      applyStimulus(4'b1111, 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(4'b0100, 0, 1'b0);

    $display("[TB] backpressure and early rsp_ready");
    applyStimulus(4'b1011, 10, 1'b0);
    applyStimulus(4'b0110, 0, 1'b1);

    $display("[TB] valid withdrawn before edge");
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("pulse_ready", 32'(req_ready), 32'(4'b0100));
    req_valid = '0;
    @(posedge clk);
    #1;
    checkOutput("pulse_busy", 32'(busy), 0);

    $display("[TB] reset mid-calc");
    op_x[3] = 8'd77;
    op_y[3] = 8'd3;
    load_operands();
    req_valid = 4'b1000;
    @(posedge clk);
    #1;
    req_valid = '0;
    checkOutput("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_valid", 32'(rsp_valid), 0);
    checkOutput("mid_rst_p", 32'(rsp_p), 0);
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("mid_no_rsp", 32'(rsp_valid), 0);
    end
    applyStimulus(4'b1111, 0, 1'b0);

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        op_x[r] = 8'($urandom);
        op_y[r] = 8'($urandom);
      end
      hold = $urandom_range(0, 3);
      applyStimulus(m, hold, (hold == 0) ? 1'($urandom) : 1'b0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
